// File: rtl/mprj_io_cfg_loader.sv
// mprj_io_cfg_loader: register file of per-pad configuration words plus a
// serial engine that shifts every word into the user-pad GPIO control chain
// and then strobes serial_load so all pads update together.
module mprj_io_cfg_loader #(
   parameter int                  PADS      = 38,
   parameter int                  CFG_BITS  = 13,
   parameter int                  DIV       = 1,
   parameter logic [CFG_BITS-1:0] CFG_RESET = 13'h0403
) (
   input  logic                clock,
   input  logic                resetb,
   input  logic                cfg_we,
   input  logic [5:0]          cfg_addr,
   input  logic [CFG_BITS-1:0] cfg_wdata,
   output logic [CFG_BITS-1:0] cfg_rdata,
   input  logic                xfer,
   output logic                busy,
   output logic                done,
   output logic                cfg_err,
   output logic                serial_clock,
   output logic                serial_data,
   output logic                serial_load
);

   localparam int PW = (PADS > 1) ? $clog2(PADS) : 1;
   localparam int BW = $clog2(CFG_BITS);
   localparam int CW = $clog2(2 * DIV);

   localparam logic [PW-1:0] PAD_LAST = PW'(PADS - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(CFG_BITS - 1);
   localparam logic [CW-1:0] PH_HALF  = CW'(DIV - 1);
   localparam logic [CW-1:0] PH_LAST  = CW'(2 * DIV - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_DONE} state_t;

   logic [CFG_BITS-1:0] mem_q [PADS];

   state_t        state_q;
   logic [PW-1:0] pad_q;
   logic [BW-1:0] bit_q;
   logic [CW-1:0] phase_q;
   logic          busy_q, done_q, err_q, sclk_q, sdata_q, load_q;

   logic          addr_ok;
   logic [PW-1:0] addr_idx;
   logic          last_bit;
   logic [PW-1:0] pad_d;
   logic [BW-1:0] pos_d;
   logic          sdata_d;
   logic          first_data;

   assign addr_ok  = 32'(cfg_addr) < PADS;
   assign addr_idx = cfg_addr[PW-1:0];

   // Combinational read port; out-of-range addresses read as zero.
   // NOTE: every variable assigned in always_comb gets a value on every path,
   // otherwise a latch is inferred.
   always_comb begin
      cfg_rdata = '0;
      if (addr_ok) cfg_rdata = mem_q[addr_idx];
   end

   // Select the bit that follows the one currently on serial_data: MSB of
   // the next lower pad after a word ends, else the next lower bit position.
   always_comb begin
      last_bit   = (bit_q == BIT_LAST);
      pad_d      = last_bit ? pad_q - 1'b1 : pad_q;
      pos_d      = last_bit ? BIT_LAST : BIT_LAST - bit_q - 1'b1;
      sdata_d    = mem_q[pad_d][pos_d];
      first_data = mem_q[PAD_LAST][BIT_LAST];
   end

   // Register file: writes are accepted only while no transfer is running,
   // so the stream always sees a stable snapshot of the live words.
   // NOTE: this array is reset because reset must restore the pads' default
   // configuration; plain data memories are normally left unreset.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         for (int i = 0; i < PADS; i++) mem_q[i] <= CFG_RESET;
      end else if (cfg_we && !busy_q && addr_ok) begin
         mem_q[addr_idx] <= cfg_wdata;
      end
   end

   // Transfer FSM with registered outputs: shift PADS*CFG_BITS bits, idle
   // the bus for DIV cycles, pulse the load strobe for DIV cycles, then done.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples values from before the edge.
   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         state_q <= S_IDLE;
         pad_q   <= '0;
         bit_q   <= '0;
         phase_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         sclk_q  <= 1'b0;
         sdata_q <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= cfg_we && busy_q;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (xfer) begin
                  state_q <= S_SHIFT;
                  busy_q  <= 1'b1;
                  sclk_q  <= 1'b0;
                  sdata_q <= first_data;
                  phase_q <= '0;
                  bit_q   <= '0;
                  pad_q   <= PAD_LAST;
               end else begin
                  state_q <= S_IDLE;
               end
            end
            S_SHIFT: begin
               if (phase_q == PH_LAST) begin
                  phase_q <= '0;
                  sclk_q  <= 1'b0;
                  if (last_bit) begin
                     bit_q <= '0;
                     if (pad_q == '0) begin
                        state_q <= S_LOAD;
                        sdata_q <= 1'b0;
                     end else begin
                        pad_q   <= pad_d;
                        sdata_q <= sdata_d;
                     end
                  end else begin
                     bit_q   <= bit_q + 1'b1;
                     sdata_q <= sdata_d;
                  end
               end else begin
                  phase_q <= phase_q + 1'b1;
                  if (phase_q == PH_HALF) sclk_q <= 1'b1;
               end
            end
            S_LOAD: begin
               if (phase_q == PH_LAST) begin
                  phase_q <= '0;
                  load_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  phase_q <= phase_q + 1'b1;
                  if (phase_q == PH_HALF) load_q <= 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy         = busy_q;
   assign done         = done_q;
   assign cfg_err      = err_q;
   assign serial_clock = sclk_q;
   assign serial_data  = sdata_q;
   assign serial_load  = load_q;

endmodule

// File: doc/mprj_io_cfg_loader.md
# mprj_io_cfg_loader

Management-side serial configuration engine for the user-project pad ring. It holds one configuration word per user pad in a register file written by the management core. On request, it streams all words out over a daisy-chained serial bus (clock, data, load) to the per-pad GPIO control blocks. Those blocks drive the `mprj_io_*` mode, enable and drive-select inputs of the padframe, so this block sits directly upstream of them.

## Interface
Parameters:
- `PADS`, default 38: number of user pads in the chain.
- `CFG_BITS`, default 13: configuration bits per pad.
- `DIV`, default 1: half-period of `serial_clock`, in `clock` cycles; must be ≥1.
- `CFG_RESET`, default 13'h0403: reset value of every configuration word.

Ports:
- `clock` input 1: system clock. All logic is on the rising edge.
- `resetb` input 1: asynchronous, active-low reset.
- `cfg_we` input 1: write strobe for the register file.
- `cfg_addr` input 6: pad index for both writes and reads.
- `cfg_wdata` input `CFG_BITS`: write data.
- `cfg_rdata` output `CFG_BITS`: combinational read of word `cfg_addr`. Reads 0 when `cfg_addr` ≥ `PADS`.
- `xfer` input 1: single-cycle request to start a transfer.
- `busy` output 1: high while a transfer is in progress.
- `done` output 1: one-cycle pulse when a transfer completes.
- `cfg_err` output 1: one-cycle pulse when a write is dropped.
- `serial_clock` output 1: serial shift clock to the chain.
- `serial_data` output 1: serial data to the chain.
- `serial_load` output 1: load strobe to the chain. The per-pad blocks copy their shift registers into their outputs on this strobe.

## Operation
- Register file:
  - `PADS` words of `CFG_BITS` bits each.
  - `resetb` low sets every word to `CFG_RESET`.
  - A write with `cfg_we`=1, `busy`=0 and `cfg_addr` < `PADS` updates the word on the next edge.
  - A write with `cfg_addr` ≥ `PADS` is silently ignored.
  - A write while `busy`=1 is dropped, and `cfg_err` pulses high the following cycle.
- FSM states and transitions:
  - `IDLE`: `xfer`=1 moves to `SHIFT`. `xfer` while busy is ignored and produces no error.
  - `SHIFT`: streams `PADS`×`CFG_BITS` bits.
  - `LOAD`: drives the load strobe.
  - `DONE`: lasts one cycle, then returns to `IDLE`.
- Bit order:
  - Pad `PADS-1` is sent first, pad 0 last, so pad 0 lands in the chain element nearest this block.
  - Within a word, the MSB is sent first.
- Counters:
  - A bit index counts 0..`CFG_BITS`-1, and a pad index counts `PADS-1` down to 0.
  - The phase counter is $clog2(2·`DIV`) wide.
  - Every counter wraps or clears exactly at its terminal count. No counter overflows.
- Word source: the transfer reads the live register file. This is safe because writes are blocked while busy.
- Reset mid-transfer: the FSM returns to `IDLE`, all outputs go to their reset values, and the registers return to `CFG_RESET`. No partial load is ever issued.

## Timing
- Reset values:
  - `busy`, `done`, `cfg_err`, `serial_clock`, `serial_data` and `serial_load` are all 0.
  - `cfg_rdata` reads `CFG_RESET` at the addressed index.
- Start of transfer: `xfer` is sampled at edge 0. `busy` goes to 1 and the first bit appears on `serial_data` after edge 0.
- Each bit slot is 2·`DIV` cycles:
  - First `DIV` cycles: `serial_clock`=0 with `serial_data` valid.
  - Next `DIV` cycles: `serial_clock`=1 with `serial_data` held stable.
  - `serial_data` changes only while `serial_clock` is 0, giving setup and hold of ≥`DIV` cycles around the rising edge.
- After the last bit:
  - `serial_clock`=0 and `serial_data`=0 for `DIV` cycles.
  - Then `serial_load`=1 for `DIV` cycles.
- Total `busy` high time is (2·`PADS`·`CFG_BITS` + 2)·`DIV` cycles.
- End of transfer:
  - `done`=1 for one cycle, in the cycle immediately after `busy` falls.
  - `serial_load` is 0 in that cycle.
  - A new `xfer` is accepted in that same cycle.
- All outputs are registered except `cfg_rdata`.

## Test plan
- Reset defaults: with default parameters, assert `resetb`=0 mid-run, then release.
  - Required: all outputs are 0.
  - Required: reading `cfg_rdata` at addresses 0..37 gives 13'h0403 for each.
  - Required: address 40 reads 0.
- Single transfer ordering: `PADS`=2, `CFG_BITS`=4, `DIV`=1; write pad0=4'hA, pad1=4'h3; pulse `xfer`.
  - Required: sampling `serial_data` on the `serial_clock` rising edges gives 0,0,1,1,1,0,1,0.
  - Required: `serial_load` is high for exactly 1 cycle.
  - Required: `busy` is high for exactly 18 cycles, and `done` follows in the next cycle.
- Divider: same data with `DIV`=2.
  - Required: `serial_clock` low and high phases are each 2 cycles.
  - Required: `busy` is high for 36 cycles.
  - Required: `serial_data` never changes while `serial_clock`=1.
- Blocked write: `cfg_we` to pad0 with 4'h5 during `busy`.
  - Required: `cfg_err` pulses for 1 cycle.
  - Required: pad0 still reads 4'hA after `done`.
  - Required: a repeated `xfer` while busy does not restart the transfer.
- Reset mid-transfer: assert `resetb` low after 7 cycles of `busy`.
  - Required: `serial_load` never pulses.
  - Required: all outputs are 0 immediately.
  - Required: the registers read `CFG_RESET`.
- Back-to-back: assert `xfer` in the `done` cycle.
  - Required: `busy` rises on the next cycle.
  - Required: the second stream is identical to the first.
